// File: rtl/com_sprom_arb.sv
// -----------------------------------------------------------------------------
// com_sprom_arb
//
// Shares one single-port ROM shell among N_REQ read requesters. A
// work-conserving round-robin arbiter issues at most one ROM read per cycle.
// The granted requester ID is carried through the ROM read latency so the
// returning data can be steered back to the requester that asked for it.
//
// Parameters
//   N_REQ   number of requesters, 1..16
//   DATA_W  ROM data width (same as the shell)
//   DEPTH   ROM depth; ADDR_W = $clog2(DEPTH)
//   RD_LAT  ROM read latency, rd_en to rd_data, 1..4 cycles
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_vld      per-requester request valid
//   req_addr     packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_rdy      one-hot grant (combinational, same cycle as the request)
//   rsp_vld      one-hot response strobe, no backpressure
//   rsp_data     response data shared by all requesters, qualified by rsp_vld
//   rom_rd_en    ROM shell read enable
//   rom_rd_addr  ROM shell read address
//   rom_rd_data  ROM shell read data
//
// Build option
//   COM_SPROM_ARB_OREG_EN  when defined, rsp_vld/rsp_data are registered once
//                          more (response latency RD_LAT+1); otherwise the
//                          response is presented in the cycle the ROM data
//                          arrives (latency RD_LAT).
// -----------------------------------------------------------------------------
module com_sprom_arb #(
    parameter int  N_REQ  = 4,
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 64,
    parameter int  RD_LAT = 1,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_vld,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_rdy,
    output logic [N_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rom_rd_en,
    output logic [ADDR_W-1:0]       rom_rd_addr,
    input  logic [DATA_W-1:0]       rom_rd_data
);

    // Decode a requester ID into a one-hot strobe vector.
    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (id == ID_W'(k)) begin
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

    logic [ID_W-1:0]         rr_ptr;
    logic [2*N_REQ-1:0]      vld_dbl;
    logic [2*N_REQ-1:0]      vld_shift;
    logic [N_REQ-1:0]        vld_rot;
    logic                    win_any;
    logic [ID_W-1:0]         win_off;
    logic [ID_W:0]           win_sum;
    logic [ID_W-1:0]         win_id;
    logic [N_REQ-1:0]        grant_oh;
    logic [ADDR_W-1:0]       addr_sel;

    logic [RD_LAT-1:0]       pipe_vld_p;
    logic [ID_W-1:0]         pipe_id_p [RD_LAT];
    logic                    last_vld;
    logic [ID_W-1:0]         last_id;
    logic [N_REQ-1:0]        last_oh;

    // ---- Stage: arbitration (combinational, request cycle) ----
    // Rotating the valid vector so rr_ptr lands on bit 0 turns the
    // round-robin search into a plain lowest-index priority pick.
    assign vld_dbl   = {req_vld, req_vld};
    assign vld_shift = vld_dbl >> rr_ptr;
    assign vld_rot   = vld_shift[N_REQ-1:0];

    always_comb begin
        win_any = 1'b0;
        win_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (vld_rot[k]) begin
                win_any = 1'b1;
                win_off = ID_W'(k);
            end
        end
    end

    // Undo the rotation: winner = (rr_ptr + offset) mod N_REQ.
    assign win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    assign win_id  = (win_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(win_sum - (ID_W+1)'(N_REQ))
                                                   : win_sum[ID_W-1:0];

    always_comb begin
        grant_oh = '0;
        addr_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_any && (win_id == ID_W'(k))) begin
                grant_oh[k] = 1'b1;
                addr_sel    = req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // The grant path is combinational, so it is forced low while reset is
    // asserted to keep every output quiet during reset.
    assign req_rdy     = rst_n ? grant_oh : '0;
    assign rom_rd_en   = rst_n & win_any;
    assign rom_rd_addr = (rst_n && win_any) ? addr_sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (win_any) begin
            rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end
    end

    // ---- Stage: ROM latency pipe, p0 .. p(RD_LAT-1) ----
    // Only the valid bits need reset; an ID is never looked at unless its
    // valid bit is set, which also discards in-flight reads on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_p <= '0;
        end else begin
            pipe_vld_p[0] <= rom_rd_en;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld_p[s] <= pipe_vld_p[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_id_p[0] <= win_id;
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_id_p[s] <= pipe_id_p[s-1];
        end
    end

    assign last_vld = pipe_vld_p[RD_LAT-1];
    assign last_id  = pipe_id_p[RD_LAT-1];
    assign last_oh  = last_vld ? id_to_onehot(last_id) : '0;

    // ---- Stage: response output ----
`ifdef COM_SPROM_ARB_OREG_EN
    logic [N_REQ-1:0]  rsp_vld_q;
    logic [DATA_W-1:0] rsp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= last_oh;
            if (last_vld) begin
                rsp_data_q <= rom_rd_data;
            end
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
`else
    // The ROM output is passed through in the response cycle; between
    // responses the last delivered word is replayed from a holding register
    // so rsp_data never follows unrelated ROM output.
    logic [DATA_W-1:0] rsp_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_hold <= '0;
        end else if (last_vld) begin
            rsp_hold <= rom_rd_data;
        end
    end

    assign rsp_vld  = last_oh;
    assign rsp_data = last_vld ? rom_rd_data : rsp_hold;
`endif

endmodule

// File: tb/tb_com_sprom_arb.sv
module tb_com_sprom_arb;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int RD_LAT = 3;
`ifdef COM_SPROM_ARB_OREG_EN
    localparam int RSP_LAT = RD_LAT + 1;
`else
    localparam int RSP_LAT = RD_LAT;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [DW-1:0]   rsp_data;
    logic            rom_rd_en;
    logic [AW-1:0]   rom_rd_addr;
    logic [DW-1:0]   rom_rd_data;

    com_sprom_arb #(
        .N_REQ (N),
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_addr   (req_addr),
        .req_rdy    (req_rdy),
        .rsp_vld    (rsp_vld),
        .rsp_data   (rsp_data),
        .rom_rd_en  (rom_rd_en),
        .rom_rd_addr(rom_rd_addr),
        .rom_rd_data(rom_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM shell stand-in: data appears RD_LAT cycles after the address.
    logic [DW-1:0] rom_mem [DEPTH];
    logic [AW-1:0] sh_addr [RD_LAT];

    always @(posedge clk) begin
        sh_addr[0] <= rom_rd_addr;
        for (int s = 1; s < RD_LAT; s++) sh_addr[s] <= sh_addr[s-1];
    end
    assign rom_rd_data = rom_mem[sh_addr[RD_LAT-1]];

    // Reference model: round-robin pointer plus a queue of due responses.
    int            vec;
    int            miss;
    int            m_ptr;
    int            m_cyc;
    logic [DW-1:0] m_last;
    int            q_due [$];
    int            q_id  [$];
    logic [DW-1:0] q_data[$];

    logic [N-1:0]  e_rdy;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_rvld;
    logic [DW-1:0] e_rdata;
    int            e_w;

    task automatic model_reset();
        m_ptr  = 0;
        m_last = '0;
        q_due.delete();
        q_id.delete();
        q_data.delete();
    endtask

    // Drive one cycle of requests and compute what the DUT must show.
    task automatic apply(input logic [N-1:0] v, input logic [N*AW-1:0] a);
        @(negedge clk);
        req_vld  = v;
        req_addr = a;
        #1;
        e_rvld  = '0;
        e_rdata = m_last;
        if (q_due.size() > 0 && q_due[0] == m_cyc) begin
            e_rvld  = N'(1) << q_id[0];
            e_rdata = q_data[0];
            m_last  = q_data[0];
            void'(q_due.pop_front());
            void'(q_id.pop_front());
            void'(q_data.pop_front());
        end
        e_w = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (e_w < 0 && v[j]) e_w = j;
        end
        e_rdy  = '0;
        e_en   = 1'b0;
        e_addr = '0;
        if (e_w >= 0) begin
            e_rdy[e_w] = 1'b1;
            e_en       = 1'b1;
            e_addr     = a[e_w*AW +: AW];
            q_due.push_back(m_cyc + RSP_LAT);
            q_id.push_back(e_w);
            q_data.push_back(rom_mem[e_addr]);
            m_ptr = (e_w + 1) % N;
        end
        m_cyc++;
    endtask

    function automatic logic [N*AW-1:0] pack1(input int idx, input logic [AW-1:0] ad);
        logic [N*AW-1:0] r;
        r = '0;
        r[idx*AW +: AW] = ad;
        return r;
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        req_vld  = 4'b1111;
        req_addr = {AW'(7), AW'(9), AW'(11), AW'(13)};
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        vec++; if (req_rdy !== '0)     begin miss++; $display("FAIL reset.rdy got=%b exp=0", req_rdy); end
        vec++; if (rom_rd_en !== 1'b0) begin miss++; $display("FAIL reset.rd_en got=%b exp=0", rom_rd_en); end
        vec++; if (rom_rd_addr !== '0) begin miss++; $display("FAIL reset.rd_addr got=%0d exp=0", rom_rd_addr); end
        vec++; if (rsp_vld !== '0)     begin miss++; $display("FAIL reset.rsp_vld got=%b exp=0", rsp_vld); end
        vec++; if (rsp_data !== '0)    begin miss++; $display("FAIL reset.rsp_data got=%h exp=0", rsp_data); end
        req_vld = '0;
        rst_n   = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        apply(4'b0010, pack1(1, AW'(5)));
        vec++; if (req_rdy !== 4'b0010)     begin miss++; $display("FAIL single.rdy got=%b exp=0010", req_rdy); end
        vec++; if (rom_rd_addr !== AW'(5))  begin miss++; $display("FAIL single.addr got=%0d exp=5", rom_rd_addr); end
        for (int c = 0; c < RSP_LAT; c++) begin
            apply('0, '0);
            vec++; if (rsp_vld !== e_rvld)  begin miss++; $display("FAIL single.rsp_vld cyc=%0d got=%b exp=%b", m_cyc, rsp_vld, e_rvld); end
            vec++; if (rsp_data !== e_rdata) begin miss++; $display("FAIL single.rsp_data cyc=%0d got=%h exp=%h", m_cyc, rsp_data, e_rdata); end
        end
        vec++; if (rsp_vld !== 4'b0010)     begin miss++; $display("FAIL single.final_vld got=%b exp=0010", rsp_vld); end
        vec++; if (rsp_data !== rom_mem[5]) begin miss++; $display("FAIL single.final_data got=%h exp=%h", rsp_data, rom_mem[5]); end
    endtask

    task automatic test_round_robin();
        logic [N*AW-1:0] a;
        // Grant requester 3 alone so the pointer wraps to 0.
        apply(4'b1000, pack1(3, AW'(1)));
        for (int c = 0; c < 8 + RSP_LAT; c++) begin
            for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
            apply((c < 8) ? 4'b1111 : 4'b0000, a);
            if (c < 8) begin
                vec++; if (req_rdy !== (N'(1) << (c % 4))) begin miss++; $display("FAIL rr.order c=%0d got=%b exp=%b", c, req_rdy, N'(1) << (c % 4)); end
            end
            vec++; if (req_rdy !== e_rdy)     begin miss++; $display("FAIL rr.rdy cyc=%0d got=%b exp=%b", m_cyc, req_rdy, e_rdy); end
            vec++; if (rom_rd_addr !== e_addr) begin miss++; $display("FAIL rr.addr cyc=%0d got=%0d exp=%0d", m_cyc, rom_rd_addr, e_addr); end
            vec++; if (rsp_vld !== e_rvld)    begin miss++; $display("FAIL rr.rsp_vld cyc=%0d got=%b exp=%b", m_cyc, rsp_vld, e_rvld); end
            vec++; if (rsp_data !== e_rdata)  begin miss++; $display("FAIL rr.rsp_data cyc=%0d got=%h exp=%h", m_cyc, rsp_data, e_rdata); end
        end
    endtask

    task automatic test_skip_wrap();
        logic [N-1:0] pat [4];
        logic [N-1:0] exp [4];
        pat[0] = 4'b0100; exp[0] = 4'b0100;
        pat[1] = 4'b1001; exp[1] = 4'b1000;
        pat[2] = 4'b0001; exp[2] = 4'b0001;
        pat[3] = 4'b1111; exp[3] = 4'b0010;
        for (int c = 0; c < 4 + RSP_LAT; c++) begin
            apply((c < 4) ? pat[c] : 4'b0000, {AW'(c + 40), AW'(c + 30), AW'(c + 20), AW'(c + 10)});
            if (c < 4) begin
                vec++; if (req_rdy !== exp[c]) begin miss++; $display("FAIL skip.grant c=%0d got=%b exp=%b", c, req_rdy, exp[c]); end
            end
            vec++; if (rsp_vld !== e_rvld)   begin miss++; $display("FAIL skip.rsp_vld cyc=%0d got=%b exp=%b", m_cyc, rsp_vld, e_rvld); end
            vec++; if (rsp_data !== e_rdata) begin miss++; $display("FAIL skip.rsp_data cyc=%0d got=%h exp=%h", m_cyc, rsp_data, e_rdata); end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]    cv;
        logic [AW-1:0]   ca [N];
        logic [N*AW-1:0] a;
        int              raise_max;
        cv = '0;
        for (int i = 0; i < N; i++) ca[i] = '0;
        for (int c = 0; c < 400 + RSP_LAT; c++) begin
            raise_max = (c < 200) ? 1 : 5;
            for (int i = 0; i < N; i++) begin
                if (c >= 400) cv[i] = 1'b0;
                else if (!cv[i]) begin
                    if ($urandom_range(0, raise_max) == 0) begin
                        cv[i] = 1'b1;
                        ca[i] = AW'($urandom);
                    end
                end else if ($urandom_range(0, 9) == 0) cv[i] = 1'b0;
                a[i*AW +: AW] = ca[i];
            end
            apply(cv, a);
            vec++; if (req_rdy !== e_rdy)      begin miss++; $display("FAIL b2b.rdy cyc=%0d got=%b exp=%b", m_cyc, req_rdy, e_rdy); end
            vec++; if (rom_rd_en !== e_en)     begin miss++; $display("FAIL b2b.rd_en cyc=%0d got=%b exp=%b", m_cyc, rom_rd_en, e_en); end
            vec++; if (rom_rd_addr !== e_addr) begin miss++; $display("FAIL b2b.addr cyc=%0d got=%0d exp=%0d", m_cyc, rom_rd_addr, e_addr); end
            vec++; if (rsp_vld !== e_rvld)     begin miss++; $display("FAIL b2b.rsp_vld cyc=%0d got=%b exp=%b", m_cyc, rsp_vld, e_rvld); end
            vec++; if (rsp_data !== e_rdata)   begin miss++; $display("FAIL b2b.rsp_data cyc=%0d got=%h exp=%h", m_cyc, rsp_data, e_rdata); end
            if (e_w >= 0) cv[e_w] = 1'b0;
        end
    endtask

    task automatic test_reset_midflight();
        apply(4'b0100, pack1(2, AW'(33)));
        @(negedge clk);
        rst_n    = 1'b0;
        req_vld  = 4'b1111;
        req_addr = {AW'(3), AW'(4), AW'(5), AW'(6)};
        for (int c = 0; c < 3; c++) begin
            #1;
            vec++; if (req_rdy !== '0)     begin miss++; $display("FAIL midrst.rdy c=%0d got=%b exp=0", c, req_rdy); end
            vec++; if (rom_rd_en !== 1'b0) begin miss++; $display("FAIL midrst.rd_en c=%0d got=%b exp=0", c, rom_rd_en); end
            vec++; if (rom_rd_addr !== '0) begin miss++; $display("FAIL midrst.addr c=%0d got=%0d exp=0", c, rom_rd_addr); end
            vec++; if (rsp_vld !== '0)     begin miss++; $display("FAIL midrst.rsp_vld c=%0d got=%b exp=0", c, rsp_vld); end
            vec++; if (rsp_data !== '0)    begin miss++; $display("FAIL midrst.rsp_data c=%0d got=%h exp=0", c, rsp_data); end
            @(negedge clk);
        end
        req_vld = '0;
        rst_n   = 1'b1;
        model_reset();
        for (int c = 0; c < RSP_LAT + 2; c++) begin
            apply('0, '0);
            vec++; if (rsp_vld !== e_rvld)   begin miss++; $display("FAIL midrst.after_vld cyc=%0d got=%b exp=%b", m_cyc, rsp_vld, e_rvld); end
            vec++; if (rsp_data !== e_rdata) begin miss++; $display("FAIL midrst.after_data cyc=%0d got=%h exp=%h", m_cyc, rsp_data, e_rdata); end
        end
        apply(4'b1111, {AW'(12), AW'(13), AW'(14), AW'(15)});
        vec++; if (req_rdy !== 4'b0001) begin miss++; $display("FAIL midrst.ptr got=%b exp=0001", req_rdy); end
    endtask

    task automatic test_idle();
        logic [N-1:0] first_exp;
        for (int c = 0; c < 10 + RSP_LAT; c++) begin
            apply('0, {AW'(c), AW'(c + 1), AW'(c + 2), AW'(c + 3)});
            vec++; if (req_rdy !== e_rdy)    begin miss++; $display("FAIL idle.rdy cyc=%0d got=%b exp=%b", m_cyc, req_rdy, e_rdy); end
            vec++; if (rom_rd_en !== e_en)   begin miss++; $display("FAIL idle.rd_en cyc=%0d got=%b exp=%b", m_cyc, rom_rd_en, e_en); end
            vec++; if (rsp_vld !== e_rvld)   begin miss++; $display("FAIL idle.rsp_vld cyc=%0d got=%b exp=%b", m_cyc, rsp_vld, e_rvld); end
            vec++; if (rsp_data !== e_rdata) begin miss++; $display("FAIL idle.rsp_data cyc=%0d got=%h exp=%h", m_cyc, rsp_data, e_rdata); end
        end
        first_exp = N'(1) << m_ptr;
        apply(4'b1111, {AW'(60), AW'(61), AW'(62), AW'(63)});
        vec++; if (req_rdy !== first_exp) begin miss++; $display("FAIL idle.ptr_held got=%b exp=%b", req_rdy, first_exp); end
    endtask

    initial begin
        vec   = 0;
        miss  = 0;
        m_cyc = 0;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
        for (int s = 0; s < RD_LAT; s++) sh_addr[s] = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_back_to_back();
        test_reset_midflight();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
